detect_merge: RTL and testbench



---
 rtl/detect_merge.sv | 197 +++++++++++++++++++
 tb/tb_detect_merge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_merge.sv
// detect_merge: suppresses near-duplicate detection hits within a frame and,
// on the frame terminator, emits a count word followed by the merged list.
module detect_merge #(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int MAX_DETECT = 16,
  parameter int MERGE_DIST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din_data,
  input  logic        din_eot,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  output logic        dout_eot
);

  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int PW  = W_X + W_Y;
  localparam int CW  = $clog2(MAX_DETECT + 1);
  localparam int AW  = (MAX_DETECT > 1) ? $clog2(MAX_DETECT) : 1;

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_DETECT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [W_X:0]  DX_LIM = (W_X + 1)'(MERGE_DIST);
  localparam logic [W_Y:0]  DY_LIM = (W_Y + 1)'(MERGE_DIST);

  typedef enum logic [1:0] {
    COLLECT,
    SCAN,
    EMIT_COUNT,
    EMIT_LIST
  } state_t;

  state_t state, state_next;

  logic [PW-1:0] entries [MAX_DETECT];
  logic [CW-1:0] count;
  logic          overflow;
  logic [CW-1:0] idx;
  logic [CW-1:0] j;
  logic [PW-1:0] pos;

  logic [PW-1:0] entry_cur;
  logic [PW-1:0] entry_out;
  logic [W_X:0]  xa, xb, dx;
  logic [W_Y:0]  ya, yb, dy;
  logic          match;
  logic          scan_end;
  logic          in_fire;
  logic          out_fire;
  logic          last_beat;

  logic unused_din;
  assign unused_din = ^din_data[31:PW];

  assign entry_cur = entries[idx[AW-1:0]];
  assign entry_out = entries[j[AW-1:0]];
  assign scan_end  = (idx == count);
  assign in_fire   = din_valid && din_ready;
  assign out_fire  = dout_valid && dout_ready;
  assign last_beat = (j == count - ONE_C);

  // Per-axis absolute distance between the pending position and entry idx;
  // one extra bit keeps the subtraction from wrapping at the image edges.
  always_comb begin
    xa = {1'b0, pos[W_X-1:0]};
    xb = {1'b0, entry_cur[W_X-1:0]};
    ya = {1'b0, pos[PW-1:W_X]};
    yb = {1'b0, entry_cur[PW-1:W_X]};
    dx = (xa >= xb) ? (xa - xb) : (xb - xa);
    dy = (ya >= yb) ? (ya - yb) : (yb - ya);
    match = (dx <= DX_LIM) && (dy <= DY_LIM);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: collect, scan stored entries one per cycle, then emit.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (in_fire) begin
          state_next = din_eot ? EMIT_COUNT : SCAN;
        end
      end
      SCAN: begin
        if (scan_end || match) begin
          state_next = COLLECT;
        end
      end
      EMIT_COUNT: begin
        if (out_fire) begin
          state_next = (count == '0) ? COLLECT : EMIT_LIST;
        end
      end
      EMIT_LIST: begin
        if (out_fire && last_beat) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Output decode; emission beats come straight from the registered state.
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_eot   = 1'b0;
    case (state)
      COLLECT: begin
        din_ready = !rst;
      end
      EMIT_COUNT: begin
        dout_valid = 1'b1;
        dout_data  = {overflow, 15'b0, 16'(count)};
        dout_eot   = (count == '0);
      end
      EMIT_LIST: begin
        dout_valid = 1'b1;
        dout_data  = 32'(entry_out);
        dout_eot   = last_beat;
      end
      default: ;
    endcase
  end

  // Frame bookkeeping: pending position, scan index, count, overflow, emit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
      idx      <= '0;
      j        <= '0;
      pos      <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire && !din_eot) begin
            pos <= din_data[PW-1:0];
            idx <= '0;
          end
        end
        SCAN: begin
          if (scan_end) begin
            if (count < MAX_C) begin
              count <= count + ONE_C;
            end else begin
              overflow <= 1'b1;
            end
          end else if (!match) begin
            idx <= idx + ONE_C;
          end
        end
        EMIT_COUNT: begin
          if (out_fire) begin
            j <= '0;
            if (count == '0) begin
              overflow <= 1'b0;
            end
          end
        end
        EMIT_LIST: begin
          if (out_fire) begin
            j <= j + ONE_C;
            if (last_beat) begin
              count    <= '0;
              overflow <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Position storage; stale contents beyond count are never read.
  always_ff @(posedge clk) begin
    if (state == SCAN && scan_end && count < MAX_C) begin
      entries[count[AW-1:0]] <= pos;
    end
  end

endmodule

// File: tb/tb_detect_merge.sv
// tb_detect_merge: directed frames against a queue-based reference model of
// the merge rules, plus literal expectations for the documented scenarios.
module tb_detect_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] din_data;
  logic        din_eot;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        dout_eot;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q [$];
  logic [32:0] seen_q [$];
  int          model_y [$];
  int          model_x [$];
  bit          model_ov = 1'b0;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_rst   = 1'b1;
  logic [32:0] prev_beat  = '0;

  detect_merge #(
    .IMG_WIDTH (45),
    .IMG_HEIGHT(45),
    .MAX_DETECT(16),
    .MERGE_DIST(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din_data  (din_data),
    .din_eot   (din_eot),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data (dout_data),
    .dout_eot  (dout_eot)
  );

  always #5 clk = ~clk;

  // Generic comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: returns the number of cycles din_ready must stay low.
  function automatic int model_accept(input int y, input int x);
    int dy;
    int dx;
    int c;
    for (int k = 0; k < model_y.size(); k++) begin
      dy = (y > model_y[k]) ? y - model_y[k] : model_y[k] - y;
      dx = (x > model_x[k]) ? x - model_x[k] : model_x[k] - x;
      if (dx <= 4 && dy <= 4) return k + 1;
    end
    c = model_y.size();
    if (c < 16) begin
      model_y.push_back(y);
      model_x.push_back(x);
    end else begin
      model_ov = 1'b1;
    end
    return c + 1;
  endfunction

  // Reference model: frame end produces count word plus stored list.
  function automatic void model_eot();
    int   n;
    logic e;
    n = model_y.size();
    e = (n == 0);
    exp_q.push_back({e, model_ov, 15'b0, 16'(n)});
    for (int k = 0; k < n; k++) begin
      e = (k == n - 1);
      exp_q.push_back({e, 20'b0, 6'(model_y[k]), 6'(model_x[k])});
    end
    model_y.delete();
    model_x.delete();
    model_ov = 1'b0;
  endfunction

  // Drive one input beat and, for detections, measure the scan stall.
  task automatic applyStimulus(input int y, input int x, input bit eot, output int stall);
    int waited;
    int exp_stall;
    logic [19:0] junk;
    junk      = 20'($urandom);
    din_data  = {junk, 6'(y), 6'(x)};
    din_eot   = eot;
    din_valid = 1'b1;
    waited    = 0;
    stall     = 0;
    @(negedge clk);
    while (!din_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!din_ready) begin
      checkOutput("accept_timeout", 64'(din_ready), 64'(1));
      din_valid = 1'b0;
      stall = -1;
      return;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_eot   = 1'b0;
    if (eot) begin
      model_eot();
    end else begin
      exp_stall = model_accept(y, x);
      @(negedge clk);
      while (!din_ready && stall < 300) begin
        stall++;
        @(negedge clk);
      end
      checkOutput("scan_stall", 64'(stall), 64'(exp_stall));
      @(posedge clk);
      #1;
    end
  endtask

  // Run until every expected output beat has been consumed.
  task automatic drainOutput(input bit random_mode);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      dout_ready = random_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    dout_ready = 1'b1;
    if (exp_q.size() > 0) begin
      checkOutput("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  task automatic checkSeen(input string name, input int i, input logic [32:0] expected);
    logic [32:0] act;
    act = (i < seen_q.size()) ? seen_q[i] : '1;
    checkOutput(name, 64'(act), 64'(expected));
  endtask

  // Compare process: checks every output beat, hold stability and upstream stall.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (prev_valid && !prev_ready && !prev_rst) begin
        checkOutput("hold_stable", 64'({dout_valid, dout_eot, dout_data}),
                    64'({1'b1, prev_beat}));
      end
      if (dout_valid) begin
        checkOutput("upstream_stalled", 64'(din_ready), 64'(0));
        if (dout_ready) begin
          seen_q.push_back({dout_eot, dout_data});
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat actual=0x%0h expected=none",
                     {dout_eot, dout_data});
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_beat", 64'({dout_eot, dout_data}), 64'(e));
          end
        end
      end
    end
    prev_valid = dout_valid;
    prev_ready = dout_ready;
    prev_rst   = rst;
    prev_beat  = {dout_eot, dout_data};
  end

  // Directed scenarios.
  initial begin
    int s;
    int s1;
    int s2;
    int s3;
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    din_eot    = 1'b0;
    dout_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_din_ready", 64'(din_ready), 64'(0));
    checkOutput("rst_dout_valid", 64'(dout_valid), 64'(0));
    checkOutput("rst_dout_data", 64'(dout_data), 64'(0));
    checkOutput("rst_dout_eot", 64'(dout_eot), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(din_ready), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] empty frame");
    seen_q.delete();
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b0);
    checkOutput("empty_beats", 64'(seen_q.size()), 64'(1));
    checkSeen("empty_word", 0, {1'b1, 32'h0000_0000});
    @(negedge clk);
    checkOutput("next_frame_ready", 64'(din_ready), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] basic merge frame");
    seen_q.delete();
    applyStimulus(10, 10, 1'b0, s1);
    applyStimulus(12, 13, 1'b0, s2);
    applyStimulus(20, 20, 1'b0, s3);
    checkOutput("stall_first", 64'(s1), 64'(1));
    checkOutput("stall_merged", 64'(s2), 64'(1));
    checkOutput("stall_third", 64'(s3), 64'(2));
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b0);
    checkOutput("basic_beats", 64'(seen_q.size()), 64'(3));
    checkSeen("basic_count", 0, {1'b0, 32'h0000_0002});
    checkSeen("basic_pos0", 1, {1'b0, 32'h0000_028A});
    checkSeen("basic_pos1", 2, {1'b1, 32'h0000_0514});

    $display("[TB] boundary frames");
    seen_q.delete();
    applyStimulus(0, 0, 1'b0, s);
    applyStimulus(4, 4, 1'b0, s);
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b0);
    checkSeen("edge_merge_count", 0, {1'b0, 32'h0000_0001});
    seen_q.delete();
    applyStimulus(0, 0, 1'b0, s);
    applyStimulus(5, 0, 1'b0, s);
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b0);
    checkSeen("edge_apart_count", 0, {1'b0, 32'h0000_0002});
    seen_q.delete();
    applyStimulus(0, 44, 1'b0, s);
    applyStimulus(44, 0, 1'b0, s);
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b0);
    checkSeen("nowrap_count", 0, {1'b0, 32'h0000_0002});
    checkSeen("nowrap_last", 2, {1'b1, 32'h0000_0B00});

    $display("[TB] overflow frame with random output back-pressure");
    seen_q.delete();
    for (int i = 0; i < 17; i++) begin
      applyStimulus((i / 5) * 9, (i % 5) * 9, 1'b0, s);
    end
    checkOutput("stall_full", 64'(s), 64'(17));
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b1);
    checkOutput("ovf_beats", 64'(seen_q.size()), 64'(17));
    checkSeen("ovf_count", 0, {1'b0, 32'h8000_0010});
    checkSeen("ovf_last", 16, {1'b1, 32'h0000_06C0});

    $display("[TB] reset during list emission");
    seen_q.delete();
    dout_ready = 1'b0;
    applyStimulus(10, 10, 1'b0, s);
    applyStimulus(30, 30, 1'b0, s);
    applyStimulus(0, 0, 1'b1, s);
    @(negedge clk);
    checkOutput("rst_frame_count", 64'({dout_valid, dout_data}), 64'({1'b1, 32'h0000_0002}));
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    rst = 1'b1;
    model_y.delete();
    model_x.delete();
    model_ov = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("valid_after_rst", 64'(dout_valid), 64'(0));
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    seen_q.delete();
    applyStimulus(30, 30, 1'b0, s);
    applyStimulus(0, 0, 1'b1, s);
    drainOutput(1'b0);
    checkOutput("post_rst_beats", 64'(seen_q.size()), 64'(2));
    checkSeen("post_rst_count", 0, {1'b0, 32'h0000_0001});
    checkSeen("post_rst_pos", 1, {1'b1, 32'h0000_079E});

    checkOutput("exp_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
